mem_arbiter: RTL and testbench

- Shares the single-core memory map (rom, print, clint, clic, ram) between the instruction-fetch port and the data port.
- Arbitrates fairly between the two requesters and decodes the granted address against the configured base/top windows.
- Forwards the request to exactly one slave and returns its response, with an error path for unmapped addresses and unresponsive slaves.
- Sits between the core's imem/dmem interfaces and the peripheral/memory slaves.

---
 rtl/mem_arbiter_pkg.sv | 58 +++++
 rtl/mem_decoder.sv | 42 ++++
 rtl/mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter_pkg
//  Purpose  : Shared memory-map constants, enums and request type for the
//             instruction/data memory arbiter.
//  Revision : 1.0
// ============================================================================
package mem_arbiter_pkg;

  localparam int c_num_slaves = 5;

  localparam logic [31:0] c_rom_base_addr   = 32'h0000_0000;
  localparam logic [31:0] c_rom_top_addr    = 32'h0000_0080;
  localparam logic [31:0] c_print_base_addr = 32'h0100_0000;
  localparam logic [31:0] c_print_top_addr  = 32'h0100_0004;
  localparam logic [31:0] c_clint_base_addr = 32'h0200_0000;
  localparam logic [31:0] c_clint_top_addr  = 32'h0200_C000;
  localparam logic [31:0] c_clic_base_addr  = 32'h0300_0000;
  localparam logic [31:0] c_clic_top_addr   = 32'h0300_5000;
  localparam logic [31:0] c_ram_base_addr   = 32'h8000_0000;
  localparam logic [31:0] c_ram_top_addr    = 32'h9000_0000;

  typedef enum logic [2:0] {
    SLV_ROM   = 3'd0,
    SLV_PRINT = 3'd1,
    SLV_CLINT = 3'd2,
    SLV_CLIC  = 3'd3,
    SLV_RAM   = 3'd4
  } slave_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        instr;
  } req_t;

  // Selects one 32-bit lane of the packed per-slave bus using a one-hot select.
  function automatic logic [31:0] onehot_mux(
    input logic [c_num_slaves-1:0]    sel,
    input logic [c_num_slaves*32-1:0] data
  );
    logic [31:0] res;
    res = '0;
    for (int i = 0; i < c_num_slaves; i++) begin
      if (sel[i]) res = res | data[i*32 +: 32];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : mem_decoder
//  Purpose  : Combinational address decode onto the five slave windows,
//             producing a one-hot select and a hit flag.
//  Revision : 1.0
// ============================================================================
module mem_decoder
  import mem_arbiter_pkg::*;
#(
  parameter logic [31:0] ROM_BASE_ADDR   = c_rom_base_addr,
  parameter logic [31:0] ROM_TOP_ADDR    = c_rom_top_addr,
  parameter logic [31:0] PRINT_BASE_ADDR = c_print_base_addr,
  parameter logic [31:0] PRINT_TOP_ADDR  = c_print_top_addr,
  parameter logic [31:0] CLINT_BASE_ADDR = c_clint_base_addr,
  parameter logic [31:0] CLINT_TOP_ADDR  = c_clint_top_addr,
  parameter logic [31:0] CLIC_BASE_ADDR  = c_clic_base_addr,
  parameter logic [31:0] CLIC_TOP_ADDR   = c_clic_top_addr,
  parameter logic [31:0] RAM_BASE_ADDR   = c_ram_base_addr,
  parameter logic [31:0] RAM_TOP_ADDR    = c_ram_top_addr
) (
  input  logic [31:0]             addr,
  output logic [c_num_slaves-1:0] sel,
  output logic                    hit
);

  // Lane order matches slave_e: rom in lane 0 through ram in lane 4.
  localparam logic [c_num_slaves-1:0][31:0] c_base = {
    RAM_BASE_ADDR, CLIC_BASE_ADDR, CLINT_BASE_ADDR, PRINT_BASE_ADDR, ROM_BASE_ADDR
  };
  localparam logic [c_num_slaves-1:0][31:0] c_top = {
    RAM_TOP_ADDR, CLIC_TOP_ADDR, CLINT_TOP_ADDR, PRINT_TOP_ADDR, ROM_TOP_ADDR
  };

  for (genvar i = 0; i < c_num_slaves; i++) begin : g_win
    assign sel[i] = (addr >= c_base[i]) && (addr < c_top[i]);
  end

  assign hit = |sel;

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Round-robin arbiter sharing the memory map between the fetch
//             and data ports, with unmapped-address and timeout error paths.
//  Revision : 1.0
// ============================================================================
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter logic [31:0] ROM_BASE_ADDR   = c_rom_base_addr,
  parameter logic [31:0] ROM_TOP_ADDR    = c_rom_top_addr,
  parameter logic [31:0] PRINT_BASE_ADDR = c_print_base_addr,
  parameter logic [31:0] PRINT_TOP_ADDR  = c_print_top_addr,
  parameter logic [31:0] CLINT_BASE_ADDR = c_clint_base_addr,
  parameter logic [31:0] CLINT_TOP_ADDR  = c_clint_top_addr,
  parameter logic [31:0] CLIC_BASE_ADDR  = c_clic_base_addr,
  parameter logic [31:0] CLIC_TOP_ADDR   = c_clic_top_addr,
  parameter logic [31:0] RAM_BASE_ADDR   = c_ram_base_addr,
  parameter logic [31:0] RAM_TOP_ADDR    = c_ram_top_addr,
  parameter int          TIMEOUT_CYCLES  = 1024
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       imem_valid,
  input  logic [31:0]                imem_addr,
  output logic [31:0]                imem_rdata,
  output logic                       imem_ready,
  output logic                       imem_error,
  input  logic                       dmem_valid,
  input  logic [31:0]                dmem_addr,
  input  logic [31:0]                dmem_wdata,
  input  logic [3:0]                 dmem_wstrb,
  output logic [31:0]                dmem_rdata,
  output logic                       dmem_ready,
  output logic                       dmem_error,
  output logic [c_num_slaves-1:0]    slv_valid,
  output logic                       slv_instr,
  output logic [31:0]                slv_addr,
  output logic [31:0]                slv_wdata,
  output logic [3:0]                 slv_wstrb,
  input  logic [c_num_slaves*32-1:0] slv_rdata,
  input  logic [c_num_slaves-1:0]    slv_ready
);

  localparam logic [1:0] c_st_idle = ST_IDLE;
  localparam logic [1:0] c_st_busy = ST_BUSY;
  localparam logic [1:0] c_st_resp = ST_RESP;

  localparam int               c_tmo_w    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYCLES - 1);

  logic [1:0]              r_state;
  req_t                    r_req;
  logic                    r_last_instr;
  logic [c_tmo_w-1:0]      r_tmo_cnt;
  logic                    r_error;
  logic [31:0]             r_imem_rdata;
  logic [31:0]             r_dmem_rdata;

  logic                    w_any_valid;
  logic                    w_grant_instr;
  logic [c_num_slaves-1:0] w_dec_sel;
  logic                    w_dec_hit;
  logic                    w_sel_ready;
  logic                    w_done;
  logic                    w_ok;
  logic [31:0]             w_resp_rdata;

  mem_decoder #(
    .ROM_BASE_ADDR   (ROM_BASE_ADDR),
    .ROM_TOP_ADDR    (ROM_TOP_ADDR),
    .PRINT_BASE_ADDR (PRINT_BASE_ADDR),
    .PRINT_TOP_ADDR  (PRINT_TOP_ADDR),
    .CLINT_BASE_ADDR (CLINT_BASE_ADDR),
    .CLINT_TOP_ADDR  (CLINT_TOP_ADDR),
    .CLIC_BASE_ADDR  (CLIC_BASE_ADDR),
    .CLIC_TOP_ADDR   (CLIC_TOP_ADDR),
    .RAM_BASE_ADDR   (RAM_BASE_ADDR),
    .RAM_TOP_ADDR    (RAM_TOP_ADDR)
  ) u_decoder (
    .addr (r_req.addr),
    .sel  (w_dec_sel),
    .hit  (w_dec_hit)
  );

  // On a tie the port that did not win last time is served.
  always_comb begin
    w_any_valid   = imem_valid | dmem_valid;
    w_grant_instr = imem_valid & (~dmem_valid | ~r_last_instr);
    w_sel_ready   = |(w_dec_sel & slv_ready);
    w_ok          = w_dec_hit & w_sel_ready;
    w_done        = ~w_dec_hit | w_sel_ready | (r_tmo_cnt == c_tmo_last);
    w_resp_rdata  = w_ok ? onehot_mux(w_dec_sel, slv_rdata) : 32'h0;
  end

  // A miss never raises slv_valid: it is resolved in the first cycle after
  // the request is latched, which keeps miss and hit response timing aligned.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= c_st_idle;
      r_req        <= '0;
      r_last_instr <= 1'b1;
      r_tmo_cnt    <= '0;
      r_error      <= 1'b0;
      r_imem_rdata <= '0;
      r_dmem_rdata <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (w_any_valid) begin
            r_state      <= c_st_busy;
            r_last_instr <= w_grant_instr;
            r_tmo_cnt    <= '0;
            if (w_grant_instr) begin
              r_req.addr  <= imem_addr;
              r_req.wdata <= '0;
              r_req.wstrb <= '0;
              r_req.instr <= 1'b1;
            end else begin
              r_req.addr  <= dmem_addr;
              r_req.wdata <= dmem_wdata;
              r_req.wstrb <= dmem_wstrb;
              r_req.instr <= 1'b0;
            end
          end
        end
        c_st_busy: begin
          if (w_done) begin
            r_state <= c_st_resp;
            r_error <= ~w_ok;
            if (r_req.instr) r_imem_rdata <= w_resp_rdata;
            else             r_dmem_rdata <= w_resp_rdata;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + c_tmo_w'(1);
          end
        end
        c_st_resp: r_state <= c_st_idle;
        default:   r_state <= c_st_idle;
      endcase
    end
  end

  always_comb begin
    slv_valid  = (r_state == c_st_busy) ? w_dec_sel : '0;
    slv_instr  = r_req.instr;
    slv_addr   = r_req.addr;
    slv_wdata  = r_req.wdata;
    slv_wstrb  = r_req.wstrb;
    imem_ready = (r_state == c_st_resp) & r_req.instr;
    dmem_ready = (r_state == c_st_resp) & ~r_req.instr;
    imem_error = imem_ready & r_error;
    dmem_error = dmem_ready & r_error;
    imem_rdata = r_imem_rdata;
    dmem_rdata = r_dmem_rdata;
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Scoreboard bench for mem_arbiter with behavioural slaves.
//  Revision : 1.0
// ============================================================================
module tb_mem_arbiter;

  localparam int TMO = 16;
  localparam logic [31:0] WB [5] = '{32'h0, 32'h0100_0000, 32'h0200_0000, 32'h0300_0000, 32'h8000_0000};
  localparam logic [31:0] WT [5] = '{32'h80, 32'h0100_0004, 32'h0200_C000, 32'h0300_5000, 32'h9000_0000};

  typedef struct { int cyc; logic [31:0] data; logic err; } resp_t;
  typedef struct { logic [4:0] sel; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb; logic instr; int nbusy; } acc_t;

  logic         clock = 1'b0;
  logic         reset;
  logic         imem_valid, dmem_valid;
  logic [31:0]  imem_addr, dmem_addr, dmem_wdata;
  logic [3:0]   dmem_wstrb;
  logic [31:0]  imem_rdata, dmem_rdata;
  logic         imem_ready, imem_error, dmem_ready, dmem_error;
  logic [4:0]   slv_valid;
  logic         slv_instr;
  logic [31:0]  slv_addr, slv_wdata;
  logic [3:0]   slv_wstrb;
  logic [159:0] slv_rdata;
  logic [4:0]   slv_ready;

  int unsigned  cyc = 0;
  logic         rst_d = 1'b0;
  int           n_tests = 0;
  int           n_fail = 0;
  bit           last_instr = 1'b1;
  bit           noise_en = 1'b0;
  logic [31:0]  last_i = '0, last_d = '0;

  resp_t resp_i[$], resp_d[$];
  acc_t  acc_q[$];
  int    dly_q[$];

  mem_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset),
    .imem_valid(imem_valid), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .imem_error(imem_error),
    .dmem_valid(dmem_valid), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .dmem_error(dmem_error), .slv_valid(slv_valid), .slv_instr(slv_instr),
    .slv_addr(slv_addr), .slv_wdata(slv_wdata), .slv_wstrb(slv_wstrb),
    .slv_rdata(slv_rdata), .slv_ready(slv_ready)
  );

  always #5 clock = ~clock;
  always @(posedge clock) begin
    cyc   <= cyc + 1;
    rst_d <= reset;
  end

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < 5; i++) if (a >= WB[i] && a < WT[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] slave_word(input int i, input logic [31:0] a);
    if (i == 0 && a == 32'h40) return 32'h0000_0013;
    return a ^ (32'h9E37_79B9 * 32'(i + 1));
  endfunction

  always_comb begin
    slv_rdata = '0;
    for (int i = 0; i < 5; i++) slv_rdata[i*32 +: 32] = slave_word(i, slv_addr);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: actual=strobe required=none at cycle %0d", nm, cyc);
  endtask

  // Response scoreboard: compares every ready pulse against the model queue.
  always @(negedge clock) begin
    resp_t e;
    if (rst_d) begin
      check("rst_slv_valid", 32'(slv_valid), 0);
      check("rst_ready", {30'h0, imem_ready, dmem_ready}, 0);
      check("rst_error", {30'h0, imem_error, dmem_error}, 0);
      check("rst_imem_rdata", imem_rdata, 0);
      check("rst_dmem_rdata", dmem_rdata, 0);
      check("rst_slv_addr", slv_addr, 0);
      check("rst_slv_ctl", {27'h0, slv_wstrb, slv_instr}, 0);
      resp_i.delete(); resp_d.delete();
      last_i = '0; last_d = '0;
    end else begin
      if (imem_ready) begin
        if (resp_i.size() == 0) unexpected("imem_ready_unexpected");
        else begin
          e = resp_i.pop_front();
          check("imem_cycle", cyc, 32'(e.cyc));
          check("imem_rdata", imem_rdata, e.data);
          check("imem_error", 32'(imem_error), 32'(e.err));
          last_i = e.data;
        end
        check("dmem_quiet", {30'h0, dmem_ready, dmem_error}, 0);
        check("dmem_hold", dmem_rdata, last_d);
      end else begin
        check("imem_err_qual", 32'(imem_error), 0);
      end
      if (dmem_ready) begin
        if (resp_d.size() == 0) unexpected("dmem_ready_unexpected");
        else begin
          e = resp_d.pop_front();
          check("dmem_cycle", cyc, 32'(e.cyc));
          check("dmem_rdata", dmem_rdata, e.data);
          check("dmem_error", 32'(dmem_error), 32'(e.err));
          last_d = e.data;
        end
        check("imem_hold", imem_rdata, last_i);
      end else begin
        check("dmem_err_qual", 32'(dmem_error), 0);
      end
    end
  end

  // Slave-side monitor: access contents, stability and BUSY length.
  logic [4:0] a_prev = '0;
  acc_t       a_cur;
  int         a_cnt = 0;
  always @(negedge clock) begin
    if (rst_d) begin
      acc_q.delete();
      a_prev = '0;
    end else begin
      if (slv_valid != 0 && a_prev == 0) begin
        if (acc_q.size() == 0) unexpected("slv_access_unexpected");
        else begin
          a_cur = acc_q.pop_front();
          a_cnt = 1;
          check("slv_valid", 32'(slv_valid), 32'(a_cur.sel));
          check("slv_addr", slv_addr, a_cur.addr);
          check("slv_wstrb", 32'(slv_wstrb), 32'(a_cur.wstrb));
          check("slv_instr", 32'(slv_instr), 32'(a_cur.instr));
          if (!a_cur.instr) check("slv_wdata", slv_wdata, a_cur.wdata);
        end
      end else if (slv_valid != 0) begin
        a_cnt++;
        check("slv_valid_stable", 32'(slv_valid), 32'(a_cur.sel));
        check("slv_addr_stable", slv_addr, a_cur.addr);
      end else if (a_prev != 0) begin
        check("busy_len", 32'(a_cnt), 32'(a_cur.nbusy));
      end
      a_prev = slv_valid;
    end
  end

  // Behavioural slaves: selected slave answers after its programmed delay;
  // unselected ready lines may toggle randomly.
  initial begin
    bit active;
    int k, d;
    active = 1'b0; k = 0; d = 0;
    slv_ready = '0;
    forever begin
      @(negedge clock);
      if (rst_d) begin
        active = 1'b0;
        dly_q.delete();
        slv_ready = '0;
      end else begin
        if (slv_valid != 0) begin
          if (!active) begin
            active = 1'b1;
            k = 0;
            d = (dly_q.size() != 0) ? dly_q.pop_front() : 0;
          end else k++;
        end else active = 1'b0;
        slv_ready = ((active && k == d) ? slv_valid : 5'h0) |
                    (noise_en ? (5'($urandom) & ~slv_valid) : 5'h0);
      end
    end
  end

  // Issue one request on one or both ports from an idle arbiter, predicting
  // grant order, slave access and response cycle for each.
  task automatic issue_pair(input bit ui, input bit ud, input logic [31:0] ai,
                            input logic [31:0] ad, input logic [31:0] wd,
                            input logic [3:0] sd, input int di, input int dd);
    bit first_i, gi, gd;
    int t;
    first_i = (ui && ud) ? !last_instr : ui;
    t = int'(cyc);
    for (int n = 0; n < 2; n++) begin
      bit is_i;
      logic [31:0] a;
      int d, idx, eff;
      resp_t r;
      acc_t x;
      is_i = (n == 0) ? first_i : !first_i;
      if ((is_i && !ui) || (!is_i && !ud)) continue;
      a   = is_i ? ai : ad;
      d   = is_i ? di : dd;
      idx = decode(a);
      eff = (d > TMO - 1) ? TMO - 1 : d;
      r.err  = (idx < 0) || (d > TMO - 1);
      r.data = r.err ? 32'h0 : slave_word(idx, a);
      r.cyc  = t + 2 + ((idx < 0) ? 0 : eff);
      if (idx >= 0) begin
        x.sel = 5'(1 << idx); x.addr = a; x.wdata = wd;
        x.wstrb = is_i ? 4'h0 : sd; x.instr = is_i; x.nbusy = eff + 1;
        acc_q.push_back(x);
        dly_q.push_back(d);
      end
      if (is_i) resp_i.push_back(r); else resp_d.push_back(r);
      last_instr = is_i;
      t = r.cyc + 1;
    end
    imem_valid = ui; imem_addr = ai;
    dmem_valid = ud; dmem_addr = ad; dmem_wdata = wd; dmem_wstrb = sd;
    gi = !ui; gd = !ud;
    for (int k = 0; k < 200 && !(gi && gd); k++) begin
      @(negedge clock);
      if (imem_ready) gi = 1'b1;
      if (dmem_ready) gd = 1'b1;
      @(posedge clock); #1;
      if (gi) imem_valid = 1'b0;
      if (gd) dmem_valid = 1'b0;
    end
    if (!(gi && gd)) begin
      n_tests++; n_fail++;
      $display("FAIL handshake_timeout: actual=no_ready required=ready at cycle %0d", cyc);
      imem_valid = 1'b0; dmem_valid = 1'b0;
    end
  endtask

  function automatic logic [31:0] rand_addr();
    int w;
    w = $urandom_range(0, 5);
    if (w == 5) begin
      case ($urandom_range(0, 4))
        0: return 32'h0000_0080;
        1: return 32'h0100_0004;
        2: return 32'h0FFF_FFFF;
        3: return 32'h9000_0000;
        default: return 32'hFFFF_FFFC;
      endcase
    end
    case ($urandom_range(0, 2))
      0: return WB[w];
      1: return WT[w] - 32'h1;
      default: return WB[w] + ($urandom % (WT[w] - WB[w]));
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: actual=running required=finished at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    imem_valid = 1'b0; imem_addr = '0;
    dmem_valid = 1'b0; dmem_addr = '0; dmem_wdata = '0; dmem_wstrb = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock); #1;

    // Single fetch from rom, answered in the first BUSY cycle.
    issue_pair(1, 0, 32'h40, 32'h0, 32'h0, 4'h0, 0, 0);
    // Load at rom top (exclusive) is unmapped.
    issue_pair(0, 1, 32'h0, 32'h80, 32'h0, 4'h0, 0, 0);
    // clint slave never answers: full timeout.
    issue_pair(0, 1, 32'h0, 32'h0200_BFF8, 32'h0, 4'h0, 1000, 0);
    // clic ready on the expiry cycle, with stray readies from other slaves.
    noise_en = 1'b1;
    issue_pair(0, 1, 32'h0, 32'h0300_0010, 32'h0, 4'h0, TMO - 1, 0);
    noise_en = 1'b0;

    // Reset in the middle of a ram access.
    dmem_valid = 1'b1; dmem_addr = 32'h8000_1000; dmem_wdata = '0; dmem_wstrb = 4'h0;
    begin
      acc_t x;
      x.sel = 5'b10000; x.addr = 32'h8000_1000; x.wdata = '0; x.wstrb = 4'h0;
      x.instr = 1'b0; x.nbusy = 0;
      acc_q.push_back(x);
      dly_q.push_back(1000);
    end
    repeat (2) begin @(posedge clock); #1; end
    dmem_valid = 1'b0; reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0; last_instr = 1'b1;
    @(posedge clock); #1;

    // Fresh simultaneous request after reset: data wins the first tie.
    issue_pair(1, 1, 32'h0000_0010, 32'h8000_0000, 32'hDEAD_BEEF, 4'hF, 1, 2);
    issue_pair(1, 1, 32'h8000_0100, 32'h0100_0000, 32'h1234_5678, 4'h1, 3, 0);

    noise_en = 1'b1;
    for (int n = 0; n < 250; n++) begin
      bit ui, ud;
      ui = 1'($urandom_range(0, 1));
      ud = 1'($urandom_range(0, 1));
      if (!ui && !ud) ui = 1'b1;
      issue_pair(ui, ud, rand_addr(), rand_addr(), $urandom, 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) == 0) ? $urandom_range(12, 20) : $urandom_range(0, 4),
                 ($urandom_range(0, 3) == 0) ? $urandom_range(12, 20) : $urandom_range(0, 4));
    end
    noise_en = 1'b0;
    repeat (3) @(posedge clock);
    check("resp_i_drained", 32'(resp_i.size()), 0);
    check("resp_d_drained", 32'(resp_d.size()), 0);
    check("acc_drained", 32'(acc_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
